// File: rtl/accum_pkg.sv
// Shared types for the product accumulator: FSM state encoding and result count width.
package accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int COUNT_WIDTH = 8;

endpackage

// File: rtl/acc_adder.sv
// Sign-extends a product to ACC_WIDTH and adds it to the running accumulator.
// Define ACC_SAT_EN for sticky saturating arithmetic; otherwise the sum wraps.
module acc_adder #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0]   product,
  input  logic                 first,
  input  logic                 hold,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 saturated
);

  localparam int PW = 2*WIDTH;

  logic [ACC_WIDTH-1:0] ext_s;
  assign ext_s = {{(ACC_WIDTH-PW){product[PW-1]}}, product};

`ifdef ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // One guard bit: overflow shows up as disagreement between the two top bits.
  logic [ACC_WIDTH:0] wide_s;
  assign wide_s = {acc[ACC_WIDTH-1], acc} + {ext_s[ACC_WIDTH-1], ext_s};
`endif

  // First beat loads the product alone; a saturated frame stays pinned at its limit.
  always_comb begin
    result    = ext_s;
    saturated = 1'b0;
    if (first) begin
      result    = ext_s;
      saturated = 1'b0;
    end else if (hold) begin
      result    = acc;
      saturated = 1'b1;
    end else begin
`ifdef ACC_SAT_EN
      if (wide_s[ACC_WIDTH] != wide_s[ACC_WIDTH-1]) begin
        result    = wide_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        saturated = 1'b1;
      end else begin
        result    = wide_s[ACC_WIDTH-1:0];
        saturated = 1'b0;
      end
`else
      result    = acc + ext_s;
      saturated = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates signed products into per-frame sums with valid/ready handshakes on both sides.
// Optional macro ACC_SAT_EN selects saturating instead of wrapping accumulation.
module product_accumulator
  import accum_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 2*WIDTH+8,
  parameter int N         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*WIDTH-1:0]     Product,
  input  logic                   src_valid,
  input  logic                   src_last,
  output logic                   src_ready,
  output logic [ACC_WIDTH-1:0]   Sum,
  output logic [COUNT_WIDTH-1:0] Count,
  output logic                   dest_valid,
  input  logic                   dest_ready
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(N-1);

  state_t                 state_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic [COUNT_WIDTH-1:0] cnt_r;
  logic [ACC_WIDTH-1:0]   sum_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   dest_valid_r;
  logic                   sat_r;

  logic [ACC_WIDTH-1:0]   add_s;
  logic                   sat_s;
  logic                   accept_s;
  logic                   closing_s;

  // Ready is gated by rst so no beat can be handed over while reset is held.
  assign src_ready = (state_r == ACCUM) && !rst;
  assign accept_s  = src_valid && src_ready;
  assign closing_s = (cnt_r == LAST_IDX) || src_last;

  acc_adder #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc_adder (
    .acc       (acc_r),
    .product   (Product),
    .first     (cnt_r == {COUNT_WIDTH{1'b0}}),
    .hold      (sat_r),
    .result    (add_s),
    .saturated (sat_s)
  );

  // Frame FSM: gather beats in ACCUM, present the result in HOLD until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ACCUM;
      acc_r        <= {ACC_WIDTH{1'b0}};
      cnt_r        <= {COUNT_WIDTH{1'b0}};
      sum_r        <= {ACC_WIDTH{1'b0}};
      count_r      <= {COUNT_WIDTH{1'b0}};
      dest_valid_r <= 1'b0;
      sat_r        <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_r <= add_s;
            sat_r <= sat_s;
            cnt_r <= cnt_r + 8'd1;
            if (closing_s) begin
              sum_r        <= add_s;
              count_r      <= cnt_r + 8'd1;
              dest_valid_r <= 1'b1;
              state_r      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (dest_ready) begin
            acc_r        <= {ACC_WIDTH{1'b0}};
            cnt_r        <= {COUNT_WIDTH{1'b0}};
            sat_r        <= 1'b0;
            dest_valid_r <= 1'b0;
            state_r      <= ACCUM;
          end
        end
        default: begin
          state_r      <= ACCUM;
          acc_r        <= {ACC_WIDTH{1'b0}};
          cnt_r        <= {COUNT_WIDTH{1'b0}};
          sat_r        <= 1'b0;
          dest_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign Sum        = sum_r;
  assign Count      = count_r;
  assign dest_valid = dest_valid_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench: default-width instance plus a 33-bit accumulator instance.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] product    = 32'd0;
  logic        src_valid  = 1'b0;
  logic        src_last   = 1'b0;
  logic        src_ready;
  logic [39:0] sum;
  logic [7:0]  count;
  logic        dest_valid;
  logic        dest_ready = 1'b0;

  logic [31:0] product_w    = 32'd0;
  logic        src_valid_w  = 1'b0;
  logic        src_last_w   = 1'b0;
  logic        src_ready_w;
  logic [32:0] sum_w;
  logic [7:0]  count_w;
  logic        dest_valid_w;
  logic        dest_ready_w = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator #(.WIDTH(16), .N(4)) dut (
    .clk(clk), .rst(rst), .Product(product), .src_valid(src_valid), .src_last(src_last),
    .src_ready(src_ready), .Sum(sum), .Count(count), .dest_valid(dest_valid),
    .dest_ready(dest_ready)
  );

  product_accumulator #(.WIDTH(16), .ACC_WIDTH(33), .N(4)) dut_w (
    .clk(clk), .rst(rst), .Product(product_w), .src_valid(src_valid_w), .src_last(src_last_w),
    .src_ready(src_ready_w), .Sum(sum_w), .Count(count_w), .dest_valid(dest_valid_w),
    .dest_ready(dest_ready_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] p, input logic last);
    product   = p;
    src_valid = 1'b1;
    src_last  = last;
    tick();
    src_valid = 1'b0;
    src_last  = 1'b0;
    product   = 32'hDEAD_BEEF;
  endtask

  task automatic consume();
    dest_ready = 1'b1;
    tick();
    dest_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %b expected 0", src_ready); end
    tick();
    checks++;
    if (dest_valid !== 1'b0 || sum !== 40'd0 || count !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b sum=%0d count=%0d expected 0/0/0", dest_valid, sum, count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", src_ready); end
  endtask

  task automatic test_full_frame();
    beat(32'sd10, 1'b0);
    beat(-32'sd10, 1'b0);
    beat(32'sd100, 1'b0);
    checks++;
    if (dest_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b expected 0", dest_valid); end
    beat(-32'sd1, 1'b0);
    checks++;
    if (dest_valid !== 1'b1 || src_ready !== 1'b0) begin
      errors++; $display("FAIL full_latency: got valid=%b ready=%b expected 1/0", dest_valid, src_ready);
    end
    checks++;
    if (sum !== 40'sd99 || count !== 8'd4) begin
      errors++; $display("FAIL full_sum: got sum=%0d count=%0d expected 99/4", $signed(sum), count);
    end
    consume();
    checks++;
    if (dest_valid !== 1'b0 || src_ready !== 1'b1) begin
      errors++; $display("FAIL full_consume: got valid=%b ready=%b expected 0/1", dest_valid, src_ready);
    end
  endtask

  task automatic test_src_last();
    beat(32'sd5, 1'b0);
    beat(32'sd7, 1'b1);
    checks++;
    if (dest_valid !== 1'b1 || sum !== 40'sd12 || count !== 8'd2) begin
      errors++; $display("FAIL last_two: got valid=%b sum=%0d count=%0d expected 1/12/2", dest_valid, $signed(sum), count);
    end
    consume();
    beat(-32'sd3, 1'b1);
    checks++;
    if (dest_valid !== 1'b1 || sum !== -40'sd3 || count !== 8'd1) begin
      errors++; $display("FAIL last_single: got valid=%b sum=%0d count=%0d expected 1/-3/1", dest_valid, $signed(sum), count);
    end
    consume();
  endtask

  task automatic test_backpressure();
    beat(32'sd1, 1'b0);
    beat(32'sd2, 1'b0);
    beat(32'sd3, 1'b0);
    beat(32'sd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      src_valid = 1'b1;
      src_last  = 1'b1;
      product   = 32'sd1000 + 32'(i);
      tick();
      checks++;
      if (dest_valid !== 1'b1 || src_ready !== 1'b0 || sum !== 40'sd10 || count !== 8'd4) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b sum=%0d count=%0d expected 1/0/10/4",
                 i, dest_valid, src_ready, $signed(sum), count);
      end
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
    consume();
    checks++;
    if (src_ready !== 1'b1 || dest_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", src_ready, dest_valid);
    end
    beat(32'sd6, 1'b1);
    checks++;
    if (sum !== 40'sd6 || count !== 8'd1) begin
      errors++; $display("FAIL bp_after: got sum=%0d count=%0d expected 6/1", $signed(sum), count);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    beat(32'sd20, 1'b0);
    beat(32'sd30, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dest_valid !== 1'b0 || sum !== 40'd0 || count !== 8'd0) begin
      errors++; $display("FAIL rst_partial: got valid=%b sum=%0d count=%0d expected 0/0/0", dest_valid, $signed(sum), count);
    end
    beat(32'sd1, 1'b0);
    beat(32'sd2, 1'b0);
    beat(32'sd3, 1'b0);
    beat(32'sd4, 1'b0);
    checks++;
    if (dest_valid !== 1'b1 || sum !== 40'sd10 || count !== 8'd4) begin
      errors++; $display("FAIL rst_next_frame: got valid=%b sum=%0d count=%0d expected 1/10/4", dest_valid, $signed(sum), count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (dest_valid !== 1'b0 || src_ready !== 1'b1) begin
      errors++; $display("FAIL rst_hold: got valid=%b ready=%b expected 0/1", dest_valid, src_ready);
    end
    beat(32'sd2, 1'b1);
    checks++;
    if (sum !== 40'sd2 || count !== 8'd1) begin
      errors++; $display("FAIL rst_after_hold: got sum=%0d count=%0d expected 2/1", $signed(sum), count);
    end
    consume();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        src_valid = 1'b0;
        src_last  = 1'b1;
        product   = 32'h7FFF_0000;
        tick();
        checks++;
        if (dest_valid !== 1'b0) begin errors++; $display("FAIL gap_idle[%0d]: got valid=%b expected 0", i, dest_valid); end
      end
      src_last = 1'b0;
      beat(32'sd1, 1'b0);
    end
    checks++;
    if (dest_valid !== 1'b1 || sum !== 40'sd4 || count !== 8'd4) begin
      errors++; $display("FAIL gap_sum: got valid=%b sum=%0d count=%0d expected 1/4/4", dest_valid, $signed(sum), count);
    end
    consume();
  endtask

  task automatic test_wide();
    logic [32:0] exp_w;
`ifdef ACC_SAT_EN
    exp_w = 33'sd4294967295;
`else
    exp_w = -33'sd4;
`endif
    for (int i = 0; i < 4; i++) begin
      product_w   = 32'sd2147483647;
      src_valid_w = 1'b1;
      tick();
    end
    src_valid_w = 1'b0;
    checks++;
    if (dest_valid_w !== 1'b1 || sum_w !== exp_w || count_w !== 8'd4) begin
      errors++;
      $display("FAIL wide_sum: got valid=%b sum=%0d count=%0d expected 1/%0d/4",
               dest_valid_w, $signed(sum_w), count_w, $signed(exp_w));
    end
    dest_ready_w = 1'b1;
    tick();
    dest_ready_w = 1'b0;
    checks++;
    if (src_ready_w !== 1'b1 || dest_valid_w !== 1'b0) begin
      errors++; $display("FAIL wide_consume: got ready=%b valid=%b expected 1/0", src_ready_w, dest_valid_w);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_src_last();
    test_backpressure();
    test_mid_reset();
    test_gaps();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
